rtc_read_sequencer: RTL
=======================

Name: rtc_read_sequencer

Overview:
Parametrised address sequencer for RTC register reads. It steps through a table of register addresses and holds each one for a programmable dwell time, in continuous or single-sweep mode. Outputs a registered address with a valid flag, never tri-state. Sits between the top-level read/write arbitration and the RTC bus-protocol controller.

Parameters:
ADDR_W, 8, width of the register address.
NUM_ADDR, 11, number of table entries (1..16).
IDX_W, 4, index width; must satisfy 2^IDX_W >= NUM_ADDR.
DWELL, 74, clock cycles each address is held (>= 1).
CNT_W, 12, dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-low; when 0 at a posedge, block returns to reset state.
enable  in  1  level; sequencing permitted while high (upstream ORs crono / idle-read conditions).
mode  in  1  0 = continuous, 1 = single sweep; sampled only at sweep start.
start  in  1  single-cycle pulse that launches one sweep in single mode; ignored otherwise.
pause  in  1  freezes dwell counter, index and address while high.
address  out  ADDR_W  current register address; 0 when addr_valid=0.
addr_valid  out  1  address is meaningful.
idx  out  IDX_W  current table index.
busy  out  1  high in RUN.
sweep_done  out  1  one-cycle pulse at end of each complete sweep.

Behaviour:
- Reset (reset=0): state=IDLE, cnt=0, idx=0, address=0, addr_valid=0, busy=0, sweep_done=0, latched mode=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when enable=1 and either mode=0, or mode=1 and start=1. Mode is latched on this transition. The first table address is valid on the next cycle (1-cycle latency).
- RUN: address=TABLE[idx], addr_valid=1, busy=1. cnt increments each cycle unless pause=1.
- Slot boundary: when cnt==DWELL-1 and pause=0, cnt clears to 0 and idx advances. Each address is held exactly DWELL unpaused cycles.
- Last slot (idx==NUM_ADDR-1) at boundary:
  - Continuous: idx wraps to 0; sweep_done pulses in the same cycle the new idx appears; state stays RUN.
  - Single: go to DONE.
- DONE: sweep_done=1 for one cycle, addr_valid=0, address=0, then IDLE. A start pulse during DONE is ignored.
- enable=0 in any state: next cycle state=IDLE, cnt=0, idx=0, addr_valid=0, address=0. No sweep_done is emitted for an aborted sweep.
- If enable drops in the same cycle as a last-slot boundary, the abort wins and no sweep_done is emitted.
- pause and a boundary in the same cycle: pause wins; nothing advances.
- start while in RUN is ignored.
- reset=0 mid-sweep: immediate reset state at that edge; reset has priority over all other inputs.
- All outputs are registered.

Optional Feature:
- Macro: RTC_SEQ_SKIP_MASK_EN.
- With the macro defined: adds input skip_mask[NUM_ADDR-1:0]. A masked slot is skipped in zero cycles.
  - Next idx = lowest unmasked index greater than the current one. If none remains, that is end-of-sweep (wrap to the lowest unmasked index, or DONE).
  - The first slot of a sweep is the lowest unmasked index.
  - All slots masked, single mode: start goes directly to DONE (sweep_done pulses, addr_valid never set).
  - All slots masked, continuous mode: stays in RUN with addr_valid=0 and no sweep_done.
  - skip_mask is sampled at every slot boundary.
- Without the macro: no port; every slot is visited.

Decomposition:
- Package rtc_seq_pkg holds:
  - the address table constant (0x21–0x28, 0x41, 0x42, 0x43);
  - the state encoding (IDLE, RUN, DONE);
  - the default DWELL value.
- Sub-module rtc_addr_rom: combinational index-to-address lookup; out-of-range index returns 0.
- The next-index/skip logic stays in the top module.

Test Plan:
- DWELL=4, mode=0, enable held high: addresses 0x21..0x28, 0x41, 0x42, 0x43, each for 4 cycles; first 0x21 one cycle after enable; sweep_done pulses when 0x21 reappears after 44 cycles.
- mode=1, single start pulse: one sweep of 44 cycles, then DONE; sweep_done=1 for one cycle; addr_valid=0 afterwards; a second start pulse during the sweep has no effect.
- enable dropped while 0x24 is held: next cycle address=0, addr_valid=0, idx=0, no sweep_done; re-enable restarts at 0x21.
- pause high for 10 cycles mid-slot on 0x26: address stays 0x26 for DWELL+10 cycles total.
- reset=0 for one cycle during 0x42: all outputs zero next cycle; a mode change applied during RUN takes effect only at the next sweep start.
- RTC_SEQ_SKIP_MASK_EN, skip_mask=0x0F0 (slots 4–7 masked): sequence 0x21, 0x22, 0x23, 0x24, 0x41, 0x42, 0x43; all-ones mask in single mode gives an immediate sweep_done.

Source files
------------

// File: rtl/rtc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_seq_pkg
// Description : Shared state encoding, RTC register address table and
//               default dwell length for the RTC read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int c_DWELL_DEFAULT = 74;
    localparam int c_TABLE_LEN     = 11;

    // Time/date registers first, then the three status registers.
    localparam logic [7:0] c_ADDR_TABLE [c_TABLE_LEN] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
        8'h27, 8'h28, 8'h41, 8'h42, 8'h43
    };

endpackage
`default_nettype wire

// File: rtl/rtc_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_read_sequencer_if
// Description : Control/status bundle between read arbitration (master) and
//               the RTC read sequencer (slave). skip_mask exists only when
//               RTC_SEQ_SKIP_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_read_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4
`ifdef RTC_SEQ_SKIP_MASK_EN
    ,
    parameter int NUM_ADDR = 11
`endif
);
    logic              enable;
    logic              mode;
    logic              start;
    logic              pause;
`ifdef RTC_SEQ_SKIP_MASK_EN
    logic [NUM_ADDR-1:0] skip_mask;
`endif
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic              sweep_done;

    modport master (
`ifdef RTC_SEQ_SKIP_MASK_EN
        output skip_mask,
`endif
        output enable, mode, start, pause,
        input  address, addr_valid, idx, busy, sweep_done
    );

    modport slave (
`ifdef RTC_SEQ_SKIP_MASK_EN
        input  skip_mask,
`endif
        input  enable, mode, start, pause,
        output address, addr_valid, idx, busy, sweep_done
    );
endinterface
`default_nettype wire

// File: rtl/rtc_addr_rom.sv
`default_nettype none
// ============================================================================
// Module      : rtc_addr_rom
// Description : Combinational table-index to RTC register address lookup;
//               indices outside the table return 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_addr_rom
    import rtc_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_ADDR = 11,
    parameter int IDX_W    = 4
) (
    input  wire logic [IDX_W-1:0]  i_idx,
    output logic      [ADDR_W-1:0] o_addr
);
    always_comb begin
        o_addr = '0;
        for (int k = 0; k < c_TABLE_LEN; k++) begin
            if (k < NUM_ADDR && int'(i_idx) == k) begin
                o_addr = ADDR_W'(c_ADDR_TABLE[k]);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_read_sequencer
// Description : Steps through the RTC register table, holding each address
//               for DWELL cycles, in continuous or single-sweep mode.
//               Optional slot skipping enabled by RTC_SEQ_SKIP_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_read_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_ADDR = 11,
    parameter int IDX_W    = 4,
    parameter int DWELL    = c_DWELL_DEFAULT,
    parameter int CNT_W    = 12
) (
    input wire logic            clk,
    input wire logic            reset,
    rtc_read_sequencer_if.slave bus
);
    seq_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_mode, w_mode_nxt;
    logic                r_addr_valid, w_valid_nxt;
    logic                r_busy;
    logic                r_sweep_done, w_done_nxt;
    logic [ADDR_W-1:0]   r_address;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic [NUM_ADDR-1:0] w_mask;
    logic                w_first_found, w_next_found;
    logic [IDX_W-1:0]    w_first_idx, w_next_idx;
    logic                w_slot_end;

`ifdef RTC_SEQ_SKIP_MASK_EN
    assign w_mask = bus.skip_mask;
`else
    assign w_mask = '0;
`endif

    assign w_slot_end = (r_cnt == CNT_W'(DWELL - 1));

    // Lowest unmasked slot overall, and lowest unmasked slot after r_idx.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_next_found  = 1'b0;
        w_next_idx    = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (!w_mask[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = IDX_W'(i);
                if (i > int'(r_idx)) begin
                    w_next_found = 1'b1;
                    w_next_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_mode_nxt  = r_mode;
        w_valid_nxt = r_addr_valid;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
                if (bus.enable && (!bus.mode || bus.start)) begin
                    w_mode_nxt = bus.mode;
                    if (w_first_found) begin
                        w_state_nxt = ST_RUN;
                        w_idx_nxt   = w_first_idx;
                        w_valid_nxt = 1'b1;
                    end else if (bus.mode) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!bus.pause) begin
                    if (w_slot_end) begin
                        w_cnt_nxt = '0;
                        if (r_addr_valid && w_next_found) begin
                            w_idx_nxt = w_next_idx;
                        end else if (!r_addr_valid) begin
                            // Everything was masked; resume once a slot reappears.
                            if (w_first_found) begin
                                w_idx_nxt   = w_first_idx;
                                w_valid_nxt = 1'b1;
                            end
                        end else if (r_mode) begin
                            w_state_nxt = ST_DONE;
                            w_idx_nxt   = '0;
                            w_valid_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else if (w_first_found) begin
                            w_idx_nxt  = w_first_idx;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_idx_nxt   = '0;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
        // Abort overrides everything, including a pending sweep_done.
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    rtc_addr_rom #(
        .ADDR_W   (ADDR_W),
        .NUM_ADDR (NUM_ADDR),
        .IDX_W    (IDX_W)
    ) u_rom (
        .i_idx  (w_idx_nxt),
        .o_addr (w_rom_addr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_mode       <= 1'b0;
            r_addr_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_address    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_mode       <= w_mode_nxt;
            r_addr_valid <= w_valid_nxt;
            r_busy       <= (w_state_nxt == ST_RUN);
            r_sweep_done <= w_done_nxt;
            r_address    <= w_valid_nxt ? w_rom_addr : '0;
        end
    end

    assign bus.address    = r_address;
    assign bus.addr_valid = r_addr_valid;
    assign bus.idx        = r_idx;
    assign bus.busy       = r_busy;
    assign bus.sweep_done = r_sweep_done;

endmodule
`default_nettype wire
